video_blank_gen: RTL and testbench

- Parametrised blanking, timing-measurement and colourisation stage between a console core's raw HSync/VSync/luma outputs and the framework VGA_* outputs.
- Generalises fixed-threshold inline blanking:
  - blank window, counter width and video width are parameters;
  - counters saturate instead of wrapping;
  - measures line period and lines per frame;
  - reports sync lock and gates DE until the sync is locked.

---
 rtl/video_blank_gen.sv | 167 ++++++++++++++++
 tb/tb_video_blank_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/video_blank_gen.sv
// video_blank_gen: sync measurement, blanking, lock detect and
// colourisation between a core's raw sync/luma and the VGA outputs.
module video_blank_gen #(
  parameter int CNT_W       = 12,
  parameter int VID_W       = 8,
  parameter int H_START     = 88,
  parameter int H_END       = 1147,
  parameter int V_START     = 34,
  parameter int V_END       = 240,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [VID_W-1:0] video,
  input  logic [1:0]       col_mode,
  output logic             hs_out,
  output logic             vs_out,
  output logic             hblank,
  output logic             vblank,
  output logic             de,
  output logic [VID_W-1:0] r,
  output logic [VID_W-1:0] g,
  output logic [VID_W-1:0] b,
  output logic [CNT_W-1:0] line_period,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked
);

  if (!(H_START < H_END && H_END < (2**CNT_W) - 1 &&
        V_START < V_END)) begin : g_bad_window
    $error("video_blank_gen: bad blank window parameters");
  end

  if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_bad_lock
    $error("video_blank_gen: LOCK_FRAMES out of range");
  end

  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [CNT_W-1:0] HS_C = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] HE_C = CNT_W'(H_END);
  localparam logic [CNT_W-1:0] VS_C = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] VE_C = CNT_W'(V_END);
  localparam logic [3:0]       LF   = 4'(LOCK_FRAMES);

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W-1:0] r_line_period;
  logic [CNT_W-1:0] r_frame_lines;
  logic [3:0]       r_match;
  logic             r_old_hs;
  logic             r_old_vs;
  logic             r_hblank;
  logic             r_vblank;
  logic             r_locked;
  logic             r_hs_out;
  logic             r_vs_out;
  logic [VID_W-1:0] r_r;
  logic [VID_W-1:0] r_g;
  logic [VID_W-1:0] r_b;

  logic             w_hs_fall;
  logic             w_vs_fall;
  logic             w_h_sat;
  logic [CNT_W-1:0] w_fl_new;
  logic [3:0]       w_match_nxt;

  // Edge detection and next lock-match count
  always_comb begin
    w_hs_fall   = r_old_hs & ~hsync;
    w_vs_fall   = w_hs_fall & r_old_vs & ~vsync;
    w_h_sat     = (r_hcnt == MAXC);
    w_fl_new    = r_vcnt + 1'b1;
    w_match_nxt = r_match;
    if (w_h_sat) begin
      w_match_nxt = '0;
    end else if (w_vs_fall) begin
      if (w_fl_new == r_frame_lines && w_fl_new != '0) begin
        w_match_nxt = (r_match == LF) ? LF : r_match + 1'b1;
      end else begin
        w_match_nxt = '0;
      end
    end
  end

  // Saturating line/frame counters and period measurement
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_line_period <= '0;
      r_frame_lines <= '0;
      r_old_hs      <= 1'b0;
      r_old_vs      <= 1'b0;
    end else begin
      r_old_hs <= hsync;
      if (w_hs_fall) begin
        r_line_period <= r_hcnt + 1'b1;
        r_hcnt        <= '0;
        r_old_vs      <= vsync;
        if (w_vs_fall) begin
          r_frame_lines <= w_fl_new;
          r_vcnt        <= '0;
        end else if (r_vcnt != MAXC) begin
          r_vcnt <= r_vcnt + 1'b1;
        end
      end else if (!w_h_sat) begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  // Blank flags from pre-update counter values
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hblank <= 1'b1;
      r_vblank <= 1'b1;
    end else begin
      if (r_hcnt == HE_C) r_hblank <= 1'b1;
      else if (r_hcnt == HS_C) r_hblank <= 1'b0;
      if (r_vcnt == VE_C) r_vblank <= 1'b1;
      else if (r_vcnt == VS_C) r_vblank <= 1'b0;
    end
  end

  // Consecutive-frame match counter and lock flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_match  <= '0;
      r_locked <= 1'b0;
    end else begin
      r_match  <= w_match_nxt;
      r_locked <= (w_match_nxt == LF);
    end
  end

  // Sync delay and colourisation, one clock of latency
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_out <= 1'b0;
      r_vs_out <= 1'b0;
      r_r      <= '0;
      r_g      <= '0;
      r_b      <= '0;
    end else begin
      r_hs_out <= hsync;
      r_vs_out <= vsync;
      r_r      <= (col_mode == 2'd0 || col_mode == 2'd1) ? video : '0;
      r_g      <= (col_mode == 2'd0 || col_mode == 2'd2) ? video : '0;
      r_b      <= (col_mode == 2'd0 || col_mode == 2'd3) ? video : '0;
    end
  end

  assign hs_out      = r_hs_out;
  assign vs_out      = r_vs_out;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign de          = ~(r_hblank | r_vblank) & r_locked;
  assign r           = r_r;
  assign g           = r_g;
  assign b           = r_b;
  assign line_period = r_line_period;
  assign frame_lines = r_frame_lines;
  assign locked      = r_locked;

endmodule

// File: tb/tb_video_blank_gen.sv
// tb_video_blank_gen: random sync/video stimulus, per-cycle expected
// outputs queued from a timing model and checked by a monitor.
module tb_video_blank_gen;

  localparam int CNT_W = 8;
  localparam int VID_W = 8;
  localparam int HST   = 10;
  localparam int HEN   = 20;
  localparam int VST   = 3;
  localparam int VEN   = 15;
  localparam int LF    = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             hb;
    logic             vb;
    logic             de;
    logic [VID_W-1:0] r;
    logic [VID_W-1:0] g;
    logic [VID_W-1:0] b;
    logic [CNT_W-1:0] lp;
    logic [CNT_W-1:0] fl;
    logic             lk;
  } obs_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             hsync;
  logic             vsync;
  logic [VID_W-1:0] video;
  logic [1:0]       col_mode;
  logic             hs_out;
  logic             vs_out;
  logic             hblank;
  logic             vblank;
  logic             de;
  logic [VID_W-1:0] r;
  logic [VID_W-1:0] g;
  logic [VID_W-1:0] b;
  logic [CNT_W-1:0] line_period;
  logic [CNT_W-1:0] frame_lines;
  logic             locked;

  always #5 clk = ~clk;

  video_blank_gen #(
    .CNT_W(CNT_W), .VID_W(VID_W),
    .H_START(HST), .H_END(HEN),
    .V_START(VST), .V_END(VEN),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset),
    .hsync(hsync), .vsync(vsync),
    .video(video), .col_mode(col_mode),
    .hs_out(hs_out), .vs_out(vs_out),
    .hblank(hblank), .vblank(vblank),
    .de(de), .r(r), .g(g), .b(b),
    .line_period(line_period),
    .frame_lines(frame_lines),
    .locked(locked)
  );

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Model: clocks since last hsync fall, lines since last frame start
  int since_h, since_v, per_h, per_v, streak;
  bit prev_hs, prev_vs, hb, vb, lk;
  obs_t m;

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  task automatic model_step();
    bit hfall, lost, fend;
    int nlines;
    if (reset) begin
      since_h = 0; since_v = 0; per_h = 0; per_v = 0;
      streak = 0; prev_hs = 0; prev_vs = 0;
      hb = 1; vb = 1; lk = 0;
      m = '0;
    end else begin
      hfall = prev_hs && !hsync;
      lost  = (since_h == MAXC);
      if (since_h == HEN) hb = 1;
      else if (since_h == HST) hb = 0;
      if (since_v == VEN) vb = 1;
      else if (since_v == VST) vb = 0;
      fend = 0;
      nlines = per_v;
      if (hfall) begin
        per_h = (since_h + 1) % (MAXC + 1);
        since_h = 0;
        if (prev_vs && !vsync) begin
          fend = 1;
          nlines = (since_v + 1) % (MAXC + 1);
          since_v = 0;
        end else begin
          since_v = sat(since_v + 1);
        end
        prev_vs = vsync;
      end else begin
        since_h = sat(since_h + 1);
      end
      if (lost) streak = 0;
      else if (fend)
        streak = (nlines == per_v && nlines != 0) ?
                 ((streak + 1 > LF) ? LF : streak + 1) : 0;
      per_v = nlines;
      lk = (streak == LF);
      prev_hs = hsync;
      m.hs = hsync;
      m.vs = vsync;
      m.r  = (col_mode == 0 || col_mode == 1) ? video : '0;
      m.g  = (col_mode == 0 || col_mode == 2) ? video : '0;
      m.b  = (col_mode == 0 || col_mode == 3) ? video : '0;
    end
    m.hb = hb;
    m.vb = vb;
    m.de = !hb && !vb && lk;
    m.lp = CNT_W'(per_h);
    m.fl = CNT_W'(per_v);
    m.lk = lk;
    q.push_back(m);
  endtask

  task automatic tick(input logic rst, input logic h, input logic v);
    reset    = rst;
    hsync    = h;
    vsync    = v;
    video    = VID_W'($urandom);
    col_mode = 2'($urandom);
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic line(input int per, input logic v);
    for (int i = 0; i < per; i++) tick(1'b0, (i >= 4), v);
  endtask

  task automatic frame(input int nl);
    int per;
    for (int l = 0; l < nl; l++) begin
      per = ($urandom_range(0, 5) == 0) ? HEN + 1 :
            int'($urandom_range(25, 40));
      line(per, (l >= 3));
    end
  endtask

  // Monitor: compare each DUT output set against the queued model value
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{hs_out, vs_out, hblank, vblank, de, r, g, b,
            line_period, frame_lines, locked};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, a, e);
        $display("  hs/vs/hb/vb/de got %b%b%b%b%b want %b%b%b%b%b",
                 a.hs, a.vs, a.hb, a.vb, a.de,
                 e.hs, e.vs, e.hb, e.vb, e.de);
        $display("  lp/fl/lk got %0d/%0d/%b want %0d/%0d/%b",
                 a.lp, a.fl, a.lk, e.lp, e.fl, e.lk);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++)
      tick(1'b1, 1'($urandom), 1'($urandom));
    for (int f = 0; f < 6; f++) frame(20);
    for (int f = 0; f < 3; f++) frame(21);
    for (int f = 0; f < 3; f++) frame(20);
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b1, 1'b1);
    for (int f = 0; f < 5; f++) frame(20);
    for (int i = 0; i < 2; i++)
      tick(1'b1, 1'($urandom), 1'($urandom));
    for (int f = 0; f < 4; f++) frame(20);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
